// File: rtl/hc_sr04_scan_scheduler.sv
// hc_sr04_scan_scheduler
//
// Time-shares N_SENSORS HC-SR04 ultrasonic sensors over one measurement
// engine. Sensors in sensor_mask are fired in ascending index order. Each
// echo pulse is timed in clock cycles, and one result is posted per shot.
// A holdoff follows every shot so that one sensor's ping does not appear as
// another sensor's echo.
//
// Ports
//   ACLK         clock, rising edge
//   reset        synchronous, active-high
//   enable       continuous scanning while high
//   start        one-cycle request for a single pass over the mask
//   sensor_mask  bit i includes sensor i in the pass
//   echo         asynchronous echo pins (synchronized internally)
//   trig         trigger pins, at most one high at a time
//   busy         high whenever the sequencer is not idle
//   res_valid    one-cycle result strobe
//   res_id       sensor index of the result
//   res_width    echo high time in cycles (0 on timeout)
//   res_timeout  result is a timeout
//   scan_done    one-cycle pulse at the end of a pass
module hc_sr04_scan_scheduler #(
    parameter int N_SENSORS      = 4,
    parameter int TRIG_CYCLES    = 1000,
    parameter int ECHO_TIMEOUT   = 3_800_000,
    parameter int HOLDOFF_CYCLES = 6_000_000,
    parameter int CNT_W          = 23,
    localparam int ID_W          = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1
) (
    input  logic                 ACLK,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 start,
    input  logic [N_SENSORS-1:0] sensor_mask,
    input  logic [N_SENSORS-1:0] echo,
    output logic [N_SENSORS-1:0] trig,
    output logic                 busy,
    output logic                 res_valid,
    output logic [ID_W-1:0]      res_id,
    output logic [CNT_W-1:0]     res_width,
    output logic                 res_timeout,
    output logic                 scan_done
);

    // idx can reach N_SENSORS (one past the last sensor), which ends the pass.
    localparam int IDX_W = $clog2(N_SENSORS + 1);

    localparam logic [CNT_W-1:0] TRIG_LAST    = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLDOFF_LAST = CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT  = CNT_W'(ECHO_TIMEOUT);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_SELECT    = 3'd1;
    localparam logic [2:0] S_TRIG      = 3'd2;
    localparam logic [2:0] S_WAIT_RISE = 3'd3;
    localparam logic [2:0] S_MEASURE   = 3'd4;
    localparam logic [2:0] S_REPORT    = 3'd5;
    localparam logic [2:0] S_HOLDOFF   = 3'd6;

    logic [2:0]           state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [ID_W-1:0]      cur_q, cur_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]     width_q, width_d;
    logic                 single_q, single_d;

    logic [N_SENSORS-1:0] echo_meta_q, echo_sync_q, echo_dly_q;

    logic [N_SENSORS-1:0] trig_q, trig_d;
    logic                 busy_q, busy_d;
    logic                 res_valid_q, res_valid_d;
    logic [ID_W-1:0]      res_id_q, res_id_d;
    logic [CNT_W-1:0]     res_width_q, res_width_d;
    logic                 res_timeout_q, res_timeout_d;
    logic                 scan_done_q, scan_done_d;

    logic                 sel_found;
    logic [ID_W-1:0]      sel_idx;
    logic                 cur_echo, cur_echo_dly, echo_rise, echo_fall;
    logic                 stop_cont;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign cur_echo     = echo_sync_q[cur_q];
    assign cur_echo_dly = echo_dly_q[cur_q];
    assign echo_rise    = cur_echo & ~cur_echo_dly;
    assign echo_fall    = ~cur_echo & cur_echo_dly;

    // Continuous scanning was withdrawn; a start-initiated pass ignores enable.
    assign stop_cont    = ~single_q & ~enable;

    // Lowest set mask bit at or above idx; the loop runs downward so the
    // last hit wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = N_SENSORS - 1; i >= 0; i--) begin
            if (sensor_mask[i] && (i >= int'(idx_q))) begin
                sel_found = 1'b1;
                sel_idx   = ID_W'(i);
            end
        end
    end

    always_comb begin
        // NOTE: every next-state value starts from its hold value so no path
        // through the case leaves a signal unassigned and infers a latch.
        state_d       = state_q;
        idx_d         = idx_q;
        cur_d         = cur_q;
        cnt_d         = cnt_q;
        width_d       = width_q;
        single_d      = single_q;
        res_valid_d   = 1'b0;
        res_id_d      = res_id_q;
        res_width_d   = res_width_q;
        res_timeout_d = res_timeout_q;
        scan_done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                idx_d = '0;
                if (start) begin
                    single_d = 1'b1;
                    state_d  = S_SELECT;
                end else if (enable) begin
                    single_d = 1'b0;
                    state_d  = S_SELECT;
                end
            end

            S_SELECT: begin
                if (!sel_found) begin
                    scan_done_d = 1'b1;
                    idx_d       = '0;
                    if (enable) begin
                        single_d = 1'b0;
                        state_d  = S_SELECT;
                    end else begin
                        state_d  = S_IDLE;
                    end
                end else if (stop_cont) begin
                    state_d = S_IDLE;
                end else begin
                    cur_d   = sel_idx;
                    cnt_d   = '0;
                    state_d = S_TRIG;
                end
            end

            S_TRIG: begin
                if (cnt_q == TRIG_LAST) begin
                    cnt_d   = '0;
                    state_d = S_WAIT_RISE;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end

            S_WAIT_RISE: begin
                cnt_d = sat_inc(cnt_q);
                if (cnt_d >= TIMEOUT_CNT) begin
                    res_valid_d   = 1'b1;
                    res_id_d      = cur_q;
                    res_width_d   = '0;
                    res_timeout_d = 1'b1;
                    state_d       = S_REPORT;
                end else if (echo_rise) begin
                    // The edge cycle is already the first high cycle.
                    width_d = CNT_W'(1);
                    state_d = S_MEASURE;
                end
            end

            S_MEASURE: begin
                cnt_d = sat_inc(cnt_q);
                if (echo_fall) begin
                    res_valid_d   = 1'b1;
                    res_id_d      = cur_q;
                    res_width_d   = width_q;
                    res_timeout_d = 1'b0;
                    state_d       = S_REPORT;
                end else if (cnt_d >= TIMEOUT_CNT) begin
                    res_valid_d   = 1'b1;
                    res_id_d      = cur_q;
                    res_width_d   = '0;
                    res_timeout_d = 1'b1;
                    state_d       = S_REPORT;
                end else if (cur_echo) begin
                    width_d = sat_inc(width_q);
                end
            end

            S_REPORT: begin
                idx_d   = IDX_W'(cur_q) + IDX_W'(1);
                cnt_d   = '0;
                state_d = stop_cont ? S_IDLE : S_HOLDOFF;
            end

            S_HOLDOFF: begin
                if (stop_cont) begin
                    state_d = S_IDLE;
                end else if (cnt_q == HOLDOFF_LAST) begin
                    cnt_d   = '0;
                    state_d = S_SELECT;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from next-state values, so trig rises the cycle
    // after SELECT and the pins never glitch on state decode.
    always_comb begin
        trig_d = '0;
        for (int i = 0; i < N_SENSORS; i++) begin
            trig_d[i] = (state_d == S_TRIG) && (cur_d == ID_W'(i));
        end
        busy_d = (state_d != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its sources.
    always_ff @(posedge ACLK) begin
        // NOTE: every register, synchronizers included, is reset; nothing here
        // is a memory array that could be left uninitialized.
        if (reset) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            cur_q         <= '0;
            cnt_q         <= '0;
            width_q       <= '0;
            single_q      <= 1'b0;
            echo_meta_q   <= '0;
            echo_sync_q   <= '0;
            echo_dly_q    <= '0;
            trig_q        <= '0;
            busy_q        <= 1'b0;
            res_valid_q   <= 1'b0;
            res_id_q      <= '0;
            res_width_q   <= '0;
            res_timeout_q <= 1'b0;
            scan_done_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cur_q         <= cur_d;
            cnt_q         <= cnt_d;
            width_q       <= width_d;
            single_q      <= single_d;
            echo_meta_q   <= echo;
            echo_sync_q   <= echo_meta_q;
            echo_dly_q    <= echo_sync_q;
            trig_q        <= trig_d;
            busy_q        <= busy_d;
            res_valid_q   <= res_valid_d;
            res_id_q      <= res_id_d;
            res_width_q   <= res_width_d;
            res_timeout_q <= res_timeout_d;
            scan_done_q   <= scan_done_d;
        end
    end

    assign trig        = trig_q;
    assign busy        = busy_q;
    assign res_valid   = res_valid_q;
    assign res_id      = res_id_q;
    assign res_width   = res_width_q;
    assign res_timeout = res_timeout_q;
    assign scan_done   = scan_done_q;

endmodule

// File: tb/tb_hc_sr04_scan_scheduler.sv
// tb_hc_sr04_scan_scheduler
//
// Directed bench for hc_sr04_scan_scheduler with small timing parameters
// (N=4, TRIG=4, ECHO_TIMEOUT=50, HOLDOFF=10, CNT_W=8). Inputs are driven just
// after the falling edge, and outputs are sampled on the falling edge.
module tb_hc_sr04_scan_scheduler;

    localparam int N     = 4;
    localparam int TRIG  = 4;
    localparam int TO    = 50;
    localparam int HOLD  = 10;
    localparam int CW    = 8;

    logic          clk;
    logic          reset;
    logic          enable;
    logic          start;
    logic [N-1:0]  sensor_mask;
    logic [N-1:0]  echo;
    logic [N-1:0]  trig;
    logic          busy;
    logic          res_valid;
    logic [1:0]    res_id;
    logic [CW-1:0] res_width;
    logic          res_timeout;
    logic          scan_done;

    hc_sr04_scan_scheduler #(
        .N_SENSORS      (N),
        .TRIG_CYCLES    (TRIG),
        .ECHO_TIMEOUT   (TO),
        .HOLDOFF_CYCLES (HOLD),
        .CNT_W          (CW)
    ) dut (
        .ACLK        (clk),
        .reset       (reset),
        .enable      (enable),
        .start       (start),
        .sensor_mask (sensor_mask),
        .echo        (echo),
        .trig        (trig),
        .busy        (busy),
        .res_valid   (res_valid),
        .res_id      (res_id),
        .res_width   (res_width),
        .res_timeout (res_timeout),
        .scan_done   (scan_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int id;
        int width;
        int to;
        int cyc;
    } ev_t;

    ev_t      evq[$];
    int       cyc;
    int       sd_cnt;
    int       sd_cyc;
    int       fall_cyc;
    int       multi_trig;
    int       trig_cycles[N];
    logic [N-1:0] trig_prev;

    int total;
    int bad;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Observer: records results, scan_done pulses and trigger activity.
    initial begin
        cyc = 0; sd_cnt = 0; sd_cyc = 0; fall_cyc = 0; multi_trig = 0;
        trig_prev = '0;
        for (int i = 0; i < N; i++) trig_cycles[i] = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (res_valid === 1'b1)
                evq.push_back('{int'(res_id), int'(res_width), int'(res_timeout), cyc});
            if (scan_done === 1'b1) begin
                sd_cnt++;
                sd_cyc = cyc;
            end
            if ($countones(trig) > 1) multi_trig++;
            for (int i = 0; i < N; i++) if (trig[i] === 1'b1) trig_cycles[i]++;
            if (trig_prev != '0 && trig == '0) fall_cyc = cyc;
            trig_prev = trig;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clear_obs();
        evq.delete();
        sd_cnt = 0;
        for (int i = 0; i < N; i++) trig_cycles[i] = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    // Waits for a trigger, waits for it to fall, then answers on that
    // sensor's echo line after dly cycles for w cycles.
    task automatic shot_echo(input int dly, input int w);
        int k;
        int b;
        k = 0;
        while (trig == '0 && k < 300) begin tick(1); k++; end
        check("trig_seen", {31'd0, trig != '0}, 1);
        b = 0;
        for (int i = 0; i < N; i++) if (trig[i]) b = i;
        k = 0;
        while (trig != '0 && k < 50) begin tick(1); k++; end
        tick(dly);
        echo[b] = 1'b1;
        tick(w);
        echo[b] = 1'b0;
    endtask

    task automatic wait_events(input int n);
        int k;
        k = 0;
        while (evq.size() < n && k < 300) begin tick(1); k++; end
        check("event_count_reached", {31'd0, evq.size() >= n}, 1);
    endtask

    task automatic wait_idle(input int limit, output int took);
        took = 0;
        while (busy && took < limit) begin tick(1); took++; end
    endtask

    int took;

    initial begin
        total = 0; bad = 0;
        reset = 1'b1; enable = 1'b0; start = 1'b0;
        sensor_mask = '0; echo = '0;
        tick(3);

        // Reset state
        check("rst_trig",        {28'd0, trig}, 0);
        check("rst_busy",        {31'd0, busy}, 0);
        check("rst_res_valid",   {31'd0, res_valid}, 0);
        check("rst_res_id",      {30'd0, res_id}, 0);
        check("rst_res_width",   {24'd0, res_width}, 0);
        check("rst_res_timeout", {31'd0, res_timeout}, 0);
        check("rst_scan_done",   {31'd0, scan_done}, 0);
        reset = 1'b0;
        tick(2);

        // Single shot on sensor 0: echo 20 cycles, 5 cycles after trig falls
        clear_obs();
        sensor_mask = 4'b0001;
        pulse_start();
        check("ss_busy_after_start", {31'd0, busy}, 1);
        shot_echo(4, 20);
        wait_events(1);
        check("ss_id",      evq[0].id, 0);
        check("ss_width",   evq[0].width, 20);
        check("ss_timeout", evq[0].to, 0);
        wait_idle(60, took);
        check("ss_busy_falls", {31'd0, busy}, 0);
        check("ss_trig0_cycles", trig_cycles[0], TRIG);
        check("ss_scan_done_count", sd_cnt, 1);
        check("ss_scan_done_after_holdoff",
              {31'd0, (sd_cyc - evq[0].cyc >= HOLD + 1) && (sd_cyc - evq[0].cyc <= HOLD + 2)}, 1);
        check("ss_result_count", evq.size(), 1);

        // Timeout: sensor 2, no echo
        tick(3);
        clear_obs();
        sensor_mask = 4'b0100;
        pulse_start();
        wait_events(1);
        check("to_id",      evq[0].id, 2);
        check("to_timeout", evq[0].to, 1);
        check("to_width",   evq[0].width, 0);
        check("to_latency", evq[0].cyc - fall_cyc, TO);
        check("to_trig2_cycles", trig_cycles[2], TRIG);
        wait_idle(60, took);

        // Stuck-high echo: no rising edge, so the shot times out
        tick(3);
        clear_obs();
        sensor_mask = 4'b0001;
        echo[0] = 1'b1;
        tick(5);
        pulse_start();
        wait_events(1);
        check("stuck_id",      evq[0].id, 0);
        check("stuck_timeout", evq[0].to, 1);
        check("stuck_width",   evq[0].width, 0);
        echo[0] = 1'b0;
        wait_idle(60, took);

        // Round robin over 1010 in continuous mode: ids 1, 3, pass end, 1
        tick(3);
        clear_obs();
        multi_trig = 0;
        sensor_mask = 4'b1010;
        enable = 1'b1;
        shot_echo(3, 7);
        shot_echo(3, 7);
        shot_echo(3, 7);
        // Withdraw enable while the last shot is still in flight
        enable = 1'b0;
        wait_events(3);
        check("rr_id0", evq[0].id, 1);
        check("rr_id1", evq[1].id, 3);
        check("rr_id2", evq[2].id, 1);
        check("rr_w0", evq[0].width, 7);
        check("rr_w1", evq[1].width, 7);
        check("rr_w2", evq[2].width, 7);
        check("rr_scan_done_between",
              {31'd0, (sd_cyc > evq[1].cyc) && (sd_cyc < evq[2].cyc)}, 1);
        wait_idle(40, took);
        // Holdoff is skipped, so idle comes well before HOLD cycles
        check("rr_idle_without_holdoff", {31'd0, took < HOLD - 2}, 1);
        tick(20);
        check("rr_no_scan_done_on_stop", sd_cnt, 1);
        check("rr_trig0_never", trig_cycles[0], 0);
        check("rr_trig2_never", trig_cycles[2], 0);
        check("rr_trig1_cycles", trig_cycles[1], 2 * TRIG);
        check("rr_trig3_cycles", trig_cycles[3], TRIG);
        check("rr_one_hot_trig", multi_trig, 0);
        check("rr_result_count", evq.size(), 3);

        // Reset in the middle of MEASURE
        clear_obs();
        sensor_mask = 4'b0001;
        pulse_start();
        begin
            int k;
            k = 0;
            while (trig == '0 && k < 50) begin tick(1); k++; end
            k = 0;
            while (trig != '0 && k < 50) begin tick(1); k++; end
        end
        tick(3);
        echo[0] = 1'b1;
        tick(6);
        reset = 1'b1;
        echo[0] = 1'b0;
        tick(1);
        check("mr_trig",      {28'd0, trig}, 0);
        check("mr_busy",      {31'd0, busy}, 0);
        check("mr_res_valid", {31'd0, res_valid}, 0);
        tick(1);
        reset = 1'b0;
        tick(30);
        check("mr_no_result", evq.size(), 0);
        pulse_start();
        shot_echo(2, 9);
        wait_events(1);
        check("mr_after_id",      evq[0].id, 0);
        check("mr_after_width",   evq[0].width, 9);
        check("mr_after_timeout", evq[0].to, 0);
        wait_idle(60, took);

        // Empty mask: scan_done within 3 cycles, no trigger
        tick(3);
        clear_obs();
        sensor_mask = 4'b0000;
        pulse_start();
        tick(2);
        check("em_scan_done_fast", sd_cnt, 1);
        tick(10);
        check("em_no_trig",
              trig_cycles[0] + trig_cycles[1] + trig_cycles[2] + trig_cycles[3], 0);
        check("em_idle", {31'd0, busy}, 0);

        // Start during TRIG is ignored: exactly one pass
        clear_obs();
        sensor_mask = 4'b0001;
        pulse_start();
        begin
            int k;
            k = 0;
            while (trig == '0 && k < 50) begin tick(1); k++; end
        end
        pulse_start();
        shot_echo(3, 6);
        wait_events(1);
        wait_idle(60, took);
        tick(40);
        check("bs_result_count", evq.size(), 1);
        check("bs_scan_done_count", sd_cnt, 1);
        check("bs_trig0_cycles", trig_cycles[0], TRIG);
        check("bs_width", evq[0].width, 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
